machine: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor: PC register, instruction memory, 32x32 register file, ALU, word-addressed data memory.
- Top of the datapath; only clock and reset are ports.
- The bench preloads registers and memory, and inspects state through fixed internal hierarchy names.

---
 rtl/machine_pkg.sv | 67 ++++++
 rtl/machine_alu32.sv | 39 +++
 rtl/machine.sv | 240 ++++++++++++++++++++++++
 tb/tb_machine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/machine_pkg.sv
// machine_pkg: shared constants and types for the single-cycle MIPS-subset core.
//   - opcode / funct encodings
//   - ALU operation enum, write-back register select enum, decoded control struct
//   - TEXT_BASE, DATA_BASE and the reset PC
// The ACCM_EN macro (handled in machine.sv) enables decode of the F_ACCM funct.
package machine_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1000_0000;
  localparam logic [31:0] RESET_PC  = TEXT_BASE;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [5:0] F_ACCM = 6'h2C;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {WS_RD, WS_RT, WS_RA} wsel_e;

  // all-zero value is a no-op: no register write, no store, PC + 4
  typedef struct packed {
    logic    reg_we;
    wsel_e   wsel;
    logic    alu_imm;
    logic    imm_zext;
    alu_op_e alu_op;
    logic    mem_rd;
    logic    mem_we;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    link;
    logic    jr;
    logic    accm;
  } ctrl_t;

endpackage

// File: rtl/machine_alu32.sv
// alu32: 32-bit combinational ALU.
//   a, b   : operands (shifts and lui act on b)
//   shamt  : shift amount for sll/srl/sra
//   op     : alu_op_e
//   result : wrapped modulo 2^32, no overflow detection
//   zero   : result == 0 (drives beq/bne)
module alu32
  import machine_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/machine.sv
// machine: single-cycle MIPS-subset processor (datapath top).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (0 = in reset)
// Parameters: TEXT_FILE / DATA_FILE hex images loaded at time 0 (empty string
// skips the load), TEXT_WORDS / DATA_WORDS memory depths.
// Fixed hierarchy for external inspection: PC_reg.q (PC[31:2]), rf.r[0:31],
// data_memory.data_seg[], and the top-level inst.
// Optional feature macro ACCM_EN: adds accm (R-type funct 0x2C),
// rd = Mem[R[rs]] + R[rt]; otherwise that funct is an undefined no-op.

// PC register, holds PC[31:2]
module pc_reg #(
  parameter logic [29:0] RESET_Q = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] d,
  output logic [29:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= RESET_Q;
    else        q <= d;
endmodule

// 32x32 register file: two combinational reads, one clocked write, r[0] == 0
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] r [0:31];

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 32; i++) r[i] <= '0;
    end else if (we && wa != 5'd0) begin
      r[wa] <= wd;
    end

  // reads see the pre-edge value, so a same-cycle write is not forwarded
  assign rd1 = (ra1 == 5'd0) ? '0 : r[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : r[ra2];
endmodule

// word-addressed data memory at DATA_BASE, combinational read, clocked write
module data_mem
  import machine_pkg::*;
#(
  parameter string DATA_FILE  = "",
  parameter int    DATA_WORDS = 32768
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int DIW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  logic [31:0] data_seg [0:DATA_WORDS-1];
  logic [31:0] off;
  logic        hit;
  logic        unused_bits;

  assign off = addr - DATA_BASE;
  // wrap-around of the subtraction makes addresses below DATA_BASE miss too
  assign hit = (off[31:2] < 30'(DATA_WORDS));
  assign rd  = hit ? data_seg[off[DIW+1:2]] : '0;
  assign unused_bits = ^off[1:0];

  always_ff @(posedge clk)
    if (we && hit) data_seg[off[DIW+1:2]] <= wd;
endmodule

module machine
  import machine_pkg::*;
#(
  parameter string TEXT_FILE  = "memory.text.dat",
  parameter string DATA_FILE  = "memory.data.dat",
  parameter int    TEXT_WORDS = 1024,
  parameter int    DATA_WORDS = 32768
) (
  input  logic clk,
  input  logic reset
);
  localparam int TIW = (TEXT_WORDS > 1) ? $clog2(TEXT_WORDS) : 1;

  logic [29:0] pc_q;
  logic [31:0] pc, pc4, pc_next, br_target;
  logic [31:0] text_off;
  logic        text_hit;
  wire  [31:0] inst;
  logic [31:0] text_seg [0:TEXT_WORDS-1];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [25:0] target;
  ctrl_t       c;

  logic [31:0] rd1, rd2, imm_ext, alu_b, alu_y, dm_addr, dm_rd, wb;
  logic        alu_zero;
  logic        unused_bits;

  // ---- fetch ----
  pc_reg #(.RESET_Q(RESET_PC[31:2])) PC_reg (
    .clk(clk), .reset(reset), .d(pc_next[31:2]), .q(pc_q)
  );

  assign pc       = {pc_q, 2'b00};
  assign pc4      = pc + 32'd4;
  assign text_off = pc - TEXT_BASE;
  assign text_hit = (text_off[31:2] < 30'(TEXT_WORDS));
  // anything outside the image fetches 0 (sll $0,$0,0), a harmless no-op
  assign inst     = text_hit ? text_seg[text_off[TIW+1:2]] : '0;

  assign op     = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];
  assign target = inst[25:0];

  // ---- decode ----
  always_comb begin
    c = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  begin c.reg_we = 1'b1; c.alu_op = ALU_ADD;  end
          F_SUB:  begin c.reg_we = 1'b1; c.alu_op = ALU_SUB;  end
          F_AND:  begin c.reg_we = 1'b1; c.alu_op = ALU_AND;  end
          F_OR:   begin c.reg_we = 1'b1; c.alu_op = ALU_OR;   end
          F_XOR:  begin c.reg_we = 1'b1; c.alu_op = ALU_XOR;  end
          F_NOR:  begin c.reg_we = 1'b1; c.alu_op = ALU_NOR;  end
          F_SLT:  begin c.reg_we = 1'b1; c.alu_op = ALU_SLT;  end
          F_SLTU: begin c.reg_we = 1'b1; c.alu_op = ALU_SLTU; end
          F_SLL:  begin c.reg_we = 1'b1; c.alu_op = ALU_SLL;  end
          F_SRL:  begin c.reg_we = 1'b1; c.alu_op = ALU_SRL;  end
          F_SRA:  begin c.reg_we = 1'b1; c.alu_op = ALU_SRA;  end
          F_JR:   c.jr = 1'b1;
`ifdef ACCM_EN
          F_ACCM: begin c.reg_we = 1'b1; c.accm = 1'b1; end
`endif
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_SLTI: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.imm_zext = 1'b1;
        c.alu_op = ALU_AND;
      end
      OP_ORI: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.imm_zext = 1'b1;
        c.alu_op = ALU_OR;
      end
      OP_XORI: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.imm_zext = 1'b1;
        c.alu_op = ALU_XOR;
      end
      OP_LUI: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.imm_zext = 1'b1;
        c.alu_op = ALU_LUI;
      end
      OP_LW: begin
        c.reg_we = 1'b1; c.wsel = WS_RT; c.alu_imm = 1'b1; c.mem_rd = 1'b1;
      end
      OP_SW:  begin c.alu_imm = 1'b1; c.mem_we = 1'b1; end
      OP_BEQ: begin c.beq = 1'b1; c.alu_op = ALU_SUB; end
      OP_BNE: begin c.bne = 1'b1; c.alu_op = ALU_SUB; end
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin c.jump = 1'b1; c.link = 1'b1; c.reg_we = 1'b1; c.wsel = WS_RA; end
      default: ;
    endcase
  end

  // ---- execute ----
  regfile rf (
    .clk(clk), .reset(reset), .ra1(rs), .ra2(rt),
    .we(c.reg_we), .wa(wa), .wd(wb), .rd1(rd1), .rd2(rd2)
  );

  assign imm_ext = c.imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = c.alu_imm ? imm_ext : rd2;

  alu32 u_alu (
    .a(rd1), .b(alu_b), .shamt(shamt), .op(c.alu_op),
    .result(alu_y), .zero(alu_zero)
  );

  // ---- memory ----
  // accm addresses with R[rs] directly, everything else with the ALU sum
  assign dm_addr = c.accm ? rd1 : alu_y;

  data_mem #(.DATA_FILE(DATA_FILE), .DATA_WORDS(DATA_WORDS)) data_memory (
    .clk(clk), .addr(dm_addr), .we(c.mem_we), .wd(rd2), .rd(dm_rd)
  );

  // ---- write-back ----
  always_comb begin
    if (c.link)        wb = pc4;
    else if (c.accm)   wb = dm_rd + rd2;
    else if (c.mem_rd) wb = dm_rd;
    else               wb = alu_y;
  end

  always_comb begin
    case (c.wsel)
      WS_RT:   wa = rt;
      WS_RA:   wa = 5'd31;
      default: wa = rd;
    endcase
  end

  // ---- next PC ----
  assign br_target = pc4 + {imm_ext[29:0], 2'b00};

  always_comb begin
    pc_next = pc4;
    if (c.jr)        pc_next = rd1;
    else if (c.jump) pc_next = {pc4[31:28], target, 2'b00};
    else if ((c.beq && alu_zero) || (c.bne && !alu_zero)) pc_next = br_target;
  end

  assign unused_bits = ^{pc_next[1:0], text_off[1:0]};

endmodule

// File: tb/tb_machine.sv
// tb_machine: directed program for machine. Preloads text/data images and
// r11..r14 through hierarchy, checks reset state and PC stepping by hand,
// runs to the zero-instruction halt, then compares a table of expected
// register / memory values. accm expectations follow ACCM_EN.
module tb_machine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  machine #(.TEXT_FILE(""), .DATA_FILE("")) dut (.clk(clk), .reset(reset));

  typedef struct {
    bit          is_mem;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] prog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int im);
    return {6'(op), 5'(rs), 5'(rt), 16'(im)};
  endfunction

  function automatic logic [31:0] enc_j(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic vec_t v(bit m, int i, logic [31:0] e);
    vec_t t;
    t.is_mem = m; t.idx = i; t.exp = e;
    return t;
  endfunction

  initial begin
    bit          halted;
    logic [31:0] act;

    // ---- program (word index in comments) ----
    prog.push_back(enc_r(11, 12, 2, 0, 'h20));   // 0  add  $2,$11,$12
    prog.push_back(enc_r(11, 12, 3, 0, 'h22));   // 1  sub  $3,$11,$12
    prog.push_back(enc_i('h2B, 13, 11, 0));      // 2  sw   $11,0($13)
    prog.push_back(enc_i('h23, 13, 5, 0));       // 3  lw   $5,0($13)
    prog.push_back(enc_i('h2B, 14, 12, 0));      // 4  sw   $12,0($14)
    prog.push_back(enc_r(13, 13, 4, 0, 'h2C));   // 5  accm $4,$13,$13
    prog.push_back(enc_r(13, 11, 6, 0, 'h2C));   // 6  accm $6,$13,$11
    prog.push_back(enc_i(4, 11, 11, 1));         // 7  beq  $11,$11,+1
    prog.push_back(enc_i(8, 0, 7, 1));           // 8  addi $7,$0,1 (skipped)
    prog.push_back(enc_i(5, 11, 11, 1));         // 9  bne  $11,$11,+1
    prog.push_back(enc_i(8, 0, 8, 2));           // 10 addi $8,$0,2
    prog.push_back(enc_i(8, 0, 0, 5));           // 11 addi $0,$0,5
    prog.push_back(enc_r(11, 12, 9, 0, 'h24));   // 12 and
    prog.push_back(enc_r(11, 12, 10, 0, 'h25));  // 13 or
    prog.push_back(enc_r(11, 12, 15, 0, 'h26));  // 14 xor
    prog.push_back(enc_r(11, 12, 16, 0, 'h27));  // 15 nor
    prog.push_back(enc_r(12, 11, 17, 0, 'h2A));  // 16 slt  $17,$12,$11
    prog.push_back(enc_r(12, 11, 18, 0, 'h22));  // 17 sub  $18,$12,$11 = -23
    prog.push_back(enc_r(18, 11, 19, 0, 'h2A));  // 18 slt  $19,$18,$11
    prog.push_back(enc_r(18, 11, 20, 0, 'h2B));  // 19 sltu $20,$18,$11
    prog.push_back(enc_r(0, 11, 21, 4, 'h00));   // 20 sll  $21,$11,4
    prog.push_back(enc_r(0, 18, 22, 4, 'h03));   // 21 sra  $22,$18,4
    prog.push_back(enc_r(0, 18, 23, 4, 'h02));   // 22 srl  $23,$18,4
    prog.push_back(enc_i('h0F, 0, 24, 'h1234));  // 23 lui  $24,0x1234
    prog.push_back(enc_i('h0D, 24, 24, 'hFFFF)); // 24 ori  $24,$24,0xFFFF
    prog.push_back(enc_i('h0C, 18, 25, 'hFF00)); // 25 andi $25,$18,0xFF00
    prog.push_back(enc_i('h0E, 11, 26, 'hFFFF)); // 26 xori $26,$11,0xFFFF
    prog.push_back(enc_i('h09, 11, 27, 'hFFFF)); // 27 addiu $27,$11,-1
    prog.push_back(enc_i('h0A, 11, 28, 'hFFFF)); // 28 slti $28,$11,-1
    prog.push_back(enc_j(3, 'h010001F));         // 29 jal  -> 31
    prog.push_back(enc_i(8, 0, 29, 7));          // 30 (skipped)
    prog.push_back(enc_j(2, 'h0100021));         // 31 j    -> 33
    prog.push_back(enc_i(8, 0, 30, 9));          // 32 (skipped)
    prog.push_back(enc_i('h23, 13, 29, 4));      // 33 lw   $29,4($13)
    prog.push_back(enc_i('h0F, 0, 30, 'h0040));  // 34 lui  $30,0x0040
    prog.push_back(enc_i('h0D, 30, 30, 'h00A0)); // 35 ori  $30,$30,0xA0
    prog.push_back(enc_r(30, 0, 0, 0, 'h08));    // 36 jr   $30 -> 40
    prog.push_back(enc_i(8, 0, 1, 1));           // 37 (skipped)
    prog.push_back(enc_i(8, 0, 1, 1));           // 38 (skipped)
    prog.push_back(enc_i(8, 0, 1, 1));           // 39 (skipped)
    prog.push_back(enc_i('h2B, 0, 11, 0));       // 40 sw $11,0($0): out of range
    prog.push_back(enc_i('h23, 0, 14, 0));       // 41 lw $14,0($0): reads 0
    prog.push_back(enc_r(11, 12, 1, 0, 'h3F));   // 42 undefined funct
    prog.push_back(enc_i('h3F, 11, 1, 1));       // 43 undefined opcode
    prog.push_back(enc_i('h0F, 0, 30, 'h0040));  // 44 lui  $30,0x0040
    prog.push_back(enc_i('h0D, 30, 30, 'h1000)); // 45 ori  $30,$30,0x1000
    prog.push_back(enc_r(30, 0, 0, 0, 'h08));    // 46 jr   -> past TEXT_WORDS

    // ---- expected end state ----
    vecs.push_back(v(0, 2,  32'h0000_00DF));
    vecs.push_back(v(0, 3,  32'h0000_0017));
    vecs.push_back(v(0, 5,  32'h0000_007B));
`ifdef ACCM_EN
    vecs.push_back(v(0, 4,  32'h1001_0083));
    vecs.push_back(v(0, 6,  32'h0000_00F6));
`else
    vecs.push_back(v(0, 4,  32'h0000_0000));
    vecs.push_back(v(0, 6,  32'h0000_0000));
`endif
    vecs.push_back(v(0, 0,  32'h0000_0000));
    vecs.push_back(v(0, 7,  32'h0000_0000));
    vecs.push_back(v(0, 8,  32'h0000_0002));
    vecs.push_back(v(0, 9,  32'h0000_0060));
    vecs.push_back(v(0, 10, 32'h0000_007F));
    vecs.push_back(v(0, 15, 32'h0000_001F));
    vecs.push_back(v(0, 16, 32'hFFFF_FF80));
    vecs.push_back(v(0, 17, 32'h0000_0001));
    vecs.push_back(v(0, 18, 32'hFFFF_FFE9));
    vecs.push_back(v(0, 19, 32'h0000_0001));
    vecs.push_back(v(0, 20, 32'h0000_0000));
    vecs.push_back(v(0, 21, 32'h0000_07B0));
    vecs.push_back(v(0, 22, 32'hFFFF_FFFE));
    vecs.push_back(v(0, 23, 32'h0FFF_FFFE));
    vecs.push_back(v(0, 24, 32'h1234_FFFF));
    vecs.push_back(v(0, 25, 32'h0000_FF00));
    vecs.push_back(v(0, 26, 32'h0000_FF84));
    vecs.push_back(v(0, 27, 32'h0000_007A));
    vecs.push_back(v(0, 28, 32'h0000_0000));
    vecs.push_back(v(0, 29, 32'h0000_0064));
    vecs.push_back(v(0, 30, 32'h0040_1000));
    vecs.push_back(v(0, 31, 32'h0040_0078));
    vecs.push_back(v(0, 1,  32'h0000_0000));
    vecs.push_back(v(0, 14, 32'h0000_0000));
    vecs.push_back(v(0, 11, 32'd123));
    vecs.push_back(v(0, 12, 32'd100));
    vecs.push_back(v(0, 13, 32'h1001_0008));
    vecs.push_back(v(1, 'h4002, 32'h0000_007B));
    vecs.push_back(v(1, 'h4003, 32'h0000_0064));
    vecs.push_back(v(1, 'h4000, 32'h1111_1111));
    vecs.push_back(v(1, 'h4001, 32'h2222_2222));
    vecs.push_back(v(1, 0,      32'hA5A5_A5A5));

    // ---- preload memories while reset is held ----
    #1;
    for (int i = 0; i < 1024; i++)
      dut.text_seg[i] = (i < prog.size()) ? prog[i] : 32'h0;
    dut.data_memory.data_seg[0]      = 32'hA5A5_A5A5;
    dut.data_memory.data_seg['h4000] = 32'h1111_1111;
    dut.data_memory.data_seg['h4001] = 32'h2222_2222;
    dut.data_memory.data_seg['h4002] = 32'h0;
    dut.data_memory.data_seg['h4003] = 32'h0;
    dut.rf.r[7] = 32'hDEAD_BEEF;   // must be wiped by the reset edge at t=5

    // ---- reset release at 6 ns ----
    #5;
    reset = 1'b1;
    check("reset_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0000);
    check("reset_r7", dut.rf.r[7], 32'h0);
    dut.rf.r[11] = 32'd123;
    dut.rf.r[12] = 32'd100;
    dut.rf.r[13] = 32'h1001_0008;
    dut.rf.r[14] = 32'h1001_000C;

    // ---- PC stepping, sampled on falling edges ----
    @(negedge clk);
    check("pc_cycle0", {dut.PC_reg.q, 2'b00}, 32'h0040_0000);
    @(negedge clk);
    check("pc_cycle1", {dut.PC_reg.q, 2'b00}, 32'h0040_0004);
    check("add_r2_early", dut.rf.r[2], 32'h0000_00DF);
    @(negedge clk);
    check("pc_cycle2", {dut.PC_reg.q, 2'b00}, 32'h0040_0008);
    check("sub_r3_early", dut.rf.r[3], 32'h0000_0017);

    // ---- run to halt marker ----
    halted = 1'b0;
    for (int cyc = 0; cyc < 200 && !halted; cyc++) begin
      if (dut.inst == 32'h0) halted = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!halted) begin
      fails++;
      $display("FAIL halt: no zero instruction within 200 cycles, pc %h", {dut.PC_reg.q, 2'b00});
    end
    check("halt_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_1000);
    check("halt_inst", dut.inst, 32'h0);

    // ---- end-state table ----
    foreach (vecs[k]) begin
      if (vecs[k].is_mem) begin
        act = dut.data_memory.data_seg[vecs[k].idx];
        check($sformatf("data_seg[%h]", vecs[k].idx), act, vecs[k].exp);
      end else begin
        act = dut.rf.r[vecs[k].idx];
        check($sformatf("r%0d", vecs[k].idx), act, vecs[k].exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
